axil_mem_slave: RTL and testbench
=================================

# axil_mem_slave

AXI-Lite slave memory, parametrised successor to the single-FSM test memory. It provides independent, concurrently operating read and write channels, byte write strobes, a configurable populated depth with out-of-range error responses, and controllable error injection. It sits behind the sorter's AXI-Lite master as its backing store and is the bench target for master-side handshake checks.

## Interface
- `ADDR_WDTH`, 4: word-address width.
- `DATA_WDTH`, 32: data width; multiple of 8.
- `DEPTH`, 16: number of populated words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WDTH.
- `RAND_ERR`, 0: 1 enables pseudo-random SLVERR injection.
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `force_okay` in 1: test control; every response is OKAY except out-of-range.
- `force_error` in 1: test control; every response is SLVERR; overrides `force_okay`.
- `ar_valid` in 1, `ar_ready` out 1, `ar_address` in ADDR_WDTH.
- `r_valid` out 1, `r_ready` in 1, `r_data` out DATA_WDTH, `r_resp` out 2.
- `aw_valid` in 1, `aw_ready` out 1, `aw_address` in ADDR_WDTH.
- `w_valid` in 1, `w_ready` out 1, `w_data` in DATA_WDTH, `w_strb` in DATA_WDTH/8.
- `b_valid` out 1, `b_ready` in 1, `b_resp` out 2.

## Operation
- Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Response priority: out-of-range (addr ≥ DEPTH) → SLVERR; else `force_error` → SLVERR; else `force_okay` → OKAY; else if RAND_ERR, SLVERR when 4-bit LFSR == 4'hF; else OKAY.
- An SLVERR write does not modify memory. An SLVERR read returns `r_data` = 0.
- Read FSM: R_IDLE → R_RAM → R_OUT → R_IDLE.
  - In R_IDLE, `ar_ready` = 1; an AR handshake latches the address.
  - In R_RAM, the synchronous RAM read is issued and the response code is evaluated and latched.
  - In R_OUT, `r_valid` = 1 and is held until `r_ready`.
- Write FSM: W_IDLE → W_COMMIT → W_RESP → W_IDLE.
  - In W_IDLE, `aw_ready` = 1 until AW is captured and `w_ready` = 1 until W is captured. The two are captured independently, in either order or in the same cycle.
  - Once both are held, the FSM moves to W_COMMIT. There the response code is evaluated and the strobed write is issued: byte i is written iff `w_strb[i]`.
  - In W_RESP, `b_valid` = 1 and is held until `b_ready`.
- Read and write FSMs run fully in parallel; neither blocks the other.
- Read/write collision: if R_RAM and W_COMMIT hit the same address in the same cycle, the read returns the pre-write data (read-before-write).
- The LFSR free-runs. It advances every cycle, is seeded to 4'h1 on reset, and is sampled once per transaction at evaluation.
- An unreachable state encoding returns the FSM to its idle state on the next cycle.

## Timing
- During `rst` and in the cycle `rst` is high, all outputs are 0: ready, valid, `r_data`, and the resp signals. Memory contents are not reset.
- The ready outputs are registered. They rise in the first cycle after `rst` falls.
- Read latency: AR handshake at cycle T → `r_valid` at T+2. After the R handshake at cycle U, `ar_ready` = 1 at U+1.
- Write latency: last of AW/W captured at T → commit at T+1 → `b_valid` at T+2. After the B handshake at U, `aw_ready` and `w_ready` = 1 at U+1.
- Payloads are stable while valid is high and not yet accepted. `r_data` and `r_resp` hold their values after the handshake until the next response.
- Reset mid-transaction: the transaction is abandoned and no B or R is issued. A write whose commit cycle coincides with `rst` high is not performed.

## Structure
- Package `axil_mem_pkg` holds the response constants RESP_OKAY and RESP_SLVERR, plus the read and write state enums/localparams.
- Sub-module `axil_mem_ram_be`: one write port with byte enables and one synchronous read port, sized DEPTH × DATA_WDTH.
- The LFSR reuses the existing `random_generator` (4-bit) instance.

## Test plan
- Write 0xDEADBEEF to addr 3 with strb 4'hF, then read addr 3 → b_resp 00 and r_data 0xDEADBEEF, `r_valid` exactly 2 cycles after the AR handshake.
- Write 0x11223344 to addr 5, then write 0xAABBCCDD with strb 4'b0101 → reading addr 5 returns 0x11BB33DD.
- W presented 3 cycles before AW to addr 2; `b_ready` held low 4 cycles → `b_valid` held with `b_resp` stable, and no second write is accepted until the B handshake.
- With DEPTH=12, write to addr 13, then read addr 13 → b_resp 10, r_resp 10, r_data 0; the contents of addrs 0–11 are unchanged.
- `force_error` = 1, write 0x5 to addr 1 → b_resp 10 and memory unchanged. Then `force_error` = 0 with `force_okay` = 1 → both responses 00.
- Concurrent read and write to addr 7 (old value 0x1, new value 0x2) with R_RAM coinciding with W_COMMIT → the read returns 0x1, and a subsequent read returns 0x2. Then assert `rst` during R_OUT → `r_valid` is 0 the next cycle.

Source files
------------

// File: rtl/axil_mem_pkg.sv
// Shared constants for the AXI-Lite slave memory: response codes, FSM encodings
// and the response-priority helper.
package axil_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_RAM  = 2'd1;
  localparam logic [1:0] R_OUT  = 2'd2;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_RESP   = 2'd2;

  // Out-of-range beats forced error, which beats forced okay, which beats random error.
  function automatic logic [1:0] resp_eval(input logic oor, input logic force_err,
                                           input logic force_ok, input logic rand_hit);
    if (oor || force_err) return RESP_SLVERR;
    if (force_ok)         return RESP_OKAY;
    return rand_hit ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_mem_slave_if.sv
// AXI-Lite bus bundle between the memory slave and its master.
interface axil_mem_slave_if #(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32
);
  localparam int unsigned STRB_WDTH = DATA_WDTH / 8;

  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [1:0]           r_resp;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;
  logic [STRB_WDTH-1:0] w_strb;
  logic                 b_valid;
  logic                 b_ready;
  logic [1:0]           b_resp;

  modport slave (
    input  ar_valid, ar_address, r_ready, aw_valid, aw_address,
           w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport master (
    output ar_valid, ar_address, r_ready, aw_valid, aw_address,
           w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/axil_mem_ram_be.sv
// DEPTH x DATA_WDTH RAM: byte-enabled write port, registered read port that
// returns pre-write data on a same-address collision.
module axil_mem_ram_be #(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [ADDR_WDTH-1:0]   waddr_i,
  input  logic [DATA_WDTH-1:0]   wdata_i,
  input  logic [DATA_WDTH/8-1:0] wstrb_i,
  input  logic                   re_i,
  input  logic                   rzero_i,
  input  logic [ADDR_WDTH-1:0]   raddr_i,
  output logic [DATA_WDTH-1:0]   rdata_o
);
  localparam int unsigned STRB_WDTH = DATA_WDTH / 8;

  logic [DATA_WDTH-1:0] mem_q [DEPTH];
  logic [DATA_WDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < STRB_WDTH; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // Error reads load zero instead of touching the array.
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/random_generator.sv
// Free-running 4-bit maximal-length LFSR (x^4 + x^3 + 1), seeded on reset.
module random_generator #(
  parameter logic [3:0] SEED = 4'h1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rand_o
);
  logic [3:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  assign rand_o = lfsr_q;
endmodule

// File: rtl/axil_mem_slave.sv
// AXI-Lite slave memory with independent read/write FSMs, byte strobes,
// out-of-range and injected SLVERR responses.
module axil_mem_slave
  import axil_mem_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned DEPTH     = 16,
  parameter bit          RAND_ERR  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             force_okay,
  input  logic             force_error,
  axil_mem_slave_if.slave  bus
);
  localparam int unsigned STRB_WDTH = DATA_WDTH / 8;

  logic [3:0] lfsr;
  logic       rand_hit_c;

  logic [1:0]           rd_state_q, rd_state_d;
  logic [ADDR_WDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]           r_resp_q, r_resp_d;
  logic                 ar_ready_q, r_valid_q;
  logic                 rd_en_c, rd_zero_c;

  logic [1:0]           wr_state_q, wr_state_d;
  logic [ADDR_WDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_WDTH-1:0] wr_strb_q, wr_strb_d;
  logic                 aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]           b_resp_q, b_resp_d;
  logic                 aw_ready_q, w_ready_q, b_valid_q;
  logic                 wr_en_c;

  function automatic logic out_of_range(input logic [ADDR_WDTH-1:0] a);
    return 32'(a) >= DEPTH;
  endfunction

  random_generator #(.SEED(4'h1)) u_lfsr (.clk(clk), .rst(rst), .rand_o(lfsr));

  assign rand_hit_c = RAND_ERR && (lfsr == 4'hF);

  // Read channel next-state.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    r_resp_d   = r_resp_q;
    rd_en_c    = 1'b0;
    rd_zero_c  = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (bus.ar_valid && ar_ready_q) begin
          rd_addr_d  = bus.ar_address;
          rd_state_d = R_RAM;
        end
      end
      R_RAM: begin
        r_resp_d   = resp_eval(out_of_range(rd_addr_q), force_error, force_okay, rand_hit_c);
        rd_en_c    = 1'b1;
        rd_zero_c  = (r_resp_d == RESP_SLVERR);
        rd_state_d = R_OUT;
      end
      R_OUT: begin
        if (bus.r_ready && r_valid_q) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      r_resp_q   <= RESP_OKAY;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      r_resp_q   <= r_resp_d;
      ar_ready_q <= (rd_state_d == R_IDLE);
      r_valid_q  <= (rd_state_d == R_OUT);
    end
  end

  // Write channel next-state; AW and W are captured independently.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    b_resp_d   = b_resp_q;
    wr_en_c    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (bus.aw_valid && aw_ready_q) begin
          aw_held_d = 1'b1;
          wr_addr_d = bus.aw_address;
        end
        if (bus.w_valid && w_ready_q) begin
          w_held_d  = 1'b1;
          wr_data_d = bus.w_data;
          wr_strb_d = bus.w_strb;
        end
        if (aw_held_d && w_held_d) wr_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        b_resp_d   = resp_eval(out_of_range(wr_addr_q), force_error, force_okay, rand_hit_c);
        wr_en_c    = (b_resp_d == RESP_OKAY);
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = W_RESP;
      end
      W_RESP: begin
        if (bus.b_ready && b_valid_q) wr_state_d = W_IDLE;
      end
      default: begin
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      b_resp_q   <= b_resp_d;
      aw_ready_q <= (wr_state_d == W_IDLE) && !aw_held_d;
      w_ready_q  <= (wr_state_d == W_IDLE) && !w_held_d;
      b_valid_q  <= (wr_state_d == W_RESP);
    end
  end

  // A commit coinciding with reset is dropped.
  axil_mem_ram_be #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en_c && !rst),
    .waddr_i(wr_addr_q),
    .wdata_i(wr_data_q),
    .wstrb_i(wr_strb_q),
    .re_i   (rd_en_c),
    .rzero_i(rd_zero_c),
    .raddr_i(rd_addr_q),
    .rdata_o(bus.r_data)
  );

  assign bus.ar_ready = ar_ready_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.aw_ready = aw_ready_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench for axil_mem_slave (DEPTH=12): latency, strobes, backpressure,
// out-of-range, forced responses, read/write collision and reset abandonment.
module tb_axil_mem_slave;

  localparam int unsigned BOUND = 30;

  logic clk;
  logic rst;
  logic force_okay;
  logic force_error;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_mem [12];
  logic [31:0] rd;
  logic [1:0]  rsp;
  int          lat;

  axil_mem_slave_if #(.ADDR_WDTH(4), .DATA_WDTH(32)) bus ();

  axil_mem_slave #(
    .ADDR_WDTH(4), .DATA_WDTH(32), .DEPTH(12), .RAND_ERR(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .force_okay (force_okay),
    .force_error(force_error),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_f, w_f;
    int   c;
    bus.aw_address = a;
    bus.w_data     = d;
    bus.w_strb     = s;
    bus.aw_valid   = 1'b1;
    bus.w_valid    = 1'b1;
    c = 0;
    while ((bus.aw_valid || bus.w_valid) && c < BOUND) begin
      aw_f = bus.aw_valid && bus.aw_ready;
      w_f  = bus.w_valid && bus.w_ready;
      tick();
      c++;
      if (aw_f) bus.aw_valid = 1'b0;
      if (w_f)  bus.w_valid  = 1'b0;
    end
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    c = 0;
    while (!bus.b_valid && c < BOUND) begin
      tick();
      c++;
    end
    if (!bus.b_valid) chk("b_timeout", 32'(bus.b_valid), 32'd1);
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int l);
    int c;
    bus.ar_address = a;
    bus.ar_valid   = 1'b1;
    c = 0;
    while (!bus.ar_ready && c < BOUND) begin
      tick();
      c++;
    end
    tick();
    bus.ar_valid = 1'b0;
    l = 1;
    while (!bus.r_valid && l < BOUND) begin
      tick();
      l++;
    end
    if (!bus.r_valid) chk("r_timeout", 32'(bus.r_valid), 32'd1);
    d    = bus.r_data;
    resp = bus.r_resp;
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; force_okay = 1'b0; force_error = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_address = '0; bus.r_ready = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_address = '0; bus.w_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.b_ready = 1'b0;

    // Reset: every output low
    repeat (3) tick();
    chk("rst_ar_ready", 32'(bus.ar_ready), 32'd0);
    chk("rst_aw_ready", 32'(bus.aw_ready), 32'd0);
    chk("rst_w_ready",  32'(bus.w_ready),  32'd0);
    chk("rst_r_valid",  32'(bus.r_valid),  32'd0);
    chk("rst_b_valid",  32'(bus.b_valid),  32'd0);
    chk("rst_r_data",   bus.r_data,        32'd0);
    chk("rst_r_resp",   32'(bus.r_resp),   32'd0);
    chk("rst_b_resp",   32'(bus.b_resp),   32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ar_ready", 32'(bus.ar_ready), 32'd1);
    chk("post_rst_aw_ready", 32'(bus.aw_ready), 32'd1);
    chk("post_rst_w_ready",  32'(bus.w_ready),  32'd1);

    // Fill populated words with known contents
    for (int i = 0; i < 12; i++) begin
      exp_mem[i] = 32'hA000_0000 + 32'(i);
      axi_write(4'(i), exp_mem[i], 4'hF, rsp);
    end

    // Full-word write and read-back with latency
    axi_write(4'd3, 32'hDEADBEEF, 4'hF, rsp);
    chk("wr3_bresp", 32'(rsp), 32'd0);
    exp_mem[3] = 32'hDEADBEEF;
    axi_read(4'd3, rd, rsp, lat);
    chk("rd3_data", rd, 32'hDEADBEEF);
    chk("rd3_resp", 32'(rsp), 32'd0);
    chk("rd3_latency", 32'(lat), 32'd2);
    chk("rd3_ar_ready_after_r", 32'(bus.ar_ready), 32'd1);

    // Byte strobes
    axi_write(4'd5, 32'h11223344, 4'hF, rsp);
    axi_write(4'd5, 32'hAABBCCDD, 4'b0101, rsp);
    exp_mem[5] = 32'h11BB33DD;
    axi_read(4'd5, rd, rsp, lat);
    chk("rd5_strb_merge", rd, 32'h11BB33DD);

    // W three cycles ahead of AW, then B backpressure
    bus.w_data = 32'hCAFE0002; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.w_valid = 1'b0;
    chk("w_held_w_ready", 32'(bus.w_ready), 32'd0);
    chk("w_held_aw_ready", 32'(bus.aw_ready), 32'd1);
    tick();
    tick();
    bus.aw_address = 4'd2; bus.aw_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    chk("commit_b_valid", 32'(bus.b_valid), 32'd0);
    tick();
    chk("resp_b_valid", 32'(bus.b_valid), 32'd1);
    bus.aw_address = 4'd9; bus.w_data = 32'h0BAD0BAD; bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_b_valid",  32'(bus.b_valid),  32'd1);
      chk("bp_b_resp",   32'(bus.b_resp),   32'd0);
      chk("bp_aw_ready", 32'(bus.aw_ready), 32'd0);
      chk("bp_w_ready",  32'(bus.w_ready),  32'd0);
      tick();
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    chk("after_b_aw_ready", 32'(bus.aw_ready), 32'd1);
    chk("after_b_w_ready",  32'(bus.w_ready),  32'd1);
    chk("after_b_b_valid",  32'(bus.b_valid),  32'd0);
    exp_mem[2] = 32'hCAFE0002;
    axi_read(4'd2, rd, rsp, lat);
    chk("rd2_data", rd, 32'hCAFE0002);

    // Out of range (DEPTH=12)
    axi_write(4'd13, 32'h12345678, 4'hF, rsp);
    chk("oor_bresp", 32'(rsp), 32'd2);
    axi_read(4'd13, rd, rsp, lat);
    chk("oor_rresp", 32'(rsp), 32'd2);
    chk("oor_rdata", rd, 32'd0);

    // Forced error, then forced okay
    force_error = 1'b1;
    axi_write(4'd1, 32'h5, 4'hF, rsp);
    chk("ferr_bresp", 32'(rsp), 32'd2);
    axi_read(4'd1, rd, rsp, lat);
    chk("ferr_rresp", 32'(rsp), 32'd2);
    chk("ferr_rdata", rd, 32'd0);
    force_error = 1'b0; force_okay = 1'b1;
    axi_read(4'd1, rd, rsp, lat);
    chk("fok_rd1_unchanged", rd, 32'hA000_0001);
    chk("fok_rresp", 32'(rsp), 32'd0);
    axi_write(4'd1, 32'h6, 4'hF, rsp);
    chk("fok_bresp", 32'(rsp), 32'd0);
    exp_mem[1] = 32'h6;
    force_okay = 1'b0;

    // Read-before-write collision on addr 7
    axi_write(4'd7, 32'h1, 4'hF, rsp);
    bus.ar_address = 4'd7; bus.ar_valid = 1'b1;
    bus.aw_address = 4'd7; bus.aw_valid = 1'b1;
    bus.w_data = 32'h2; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    tick();
    chk("col_r_valid", 32'(bus.r_valid), 32'd1);
    chk("col_r_data_old", bus.r_data, 32'h1);
    chk("col_b_valid", 32'(bus.b_valid), 32'd1);
    bus.r_ready = 1'b1; bus.b_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0; bus.b_ready = 1'b0;
    exp_mem[7] = 32'h2;
    axi_read(4'd7, rd, rsp, lat);
    chk("col_rd7_new", rd, 32'h2);

    // Reset during R_OUT abandons the read
    bus.ar_address = 4'd7; bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    tick();
    chk("rout_r_valid", 32'(bus.r_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_rout_r_valid", 32'(bus.r_valid), 32'd0);
    chk("rst_rout_r_data",  bus.r_data,       32'd0);
    rst = 1'b0;
    tick();
    chk("rst_rout_ar_ready", 32'(bus.ar_ready), 32'd1);
    chk("rst_rout_no_r",     32'(bus.r_valid),  32'd0);

    // Reset coinciding with commit drops the write
    bus.aw_address = 4'd4; bus.w_data = 32'hFFFFFFFF; bus.w_strb = 4'hF;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst_commit_no_b", 32'(bus.b_valid), 32'd0);

    // Whole populated range against expected contents
    for (int i = 0; i < 12; i++) begin
      axi_read(4'(i), rd, rsp, lat);
      chk($sformatf("sweep_addr%0d", i), rd, exp_mem[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
